// File: rtl/tick_timer_arbiter_if.sv
// Request/grant bundle between requesters and the shared tick timer.
//   req   : per-requester request level
//   delay : packed per-requester delay in ticks, requester i at [i*BITS +: BITS]
//   grant : one-hot current timer owner
//   done  : one-hot, one-cycle expiry pulse for the owner
//   busy  : timer currently owned (RUN or DONE)
//   count : remaining ticks of the current grant
interface tick_timer_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned BITS = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] delay;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [BITS-1:0]      count;

  modport master (output req, delay, input grant, done, busy, count);
  modport slave  (input req, delay, output grant, done, busy, count);
endinterface

// File: rtl/tick_timer_arbiter.sv
// Round-robin shared prescaled down-counter timer.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : tick_timer_arbiter_if slave (req/delay in, grant/done/busy/count out)
module tick_timer_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned BITS          = 8,
  parameter int unsigned PRESCALE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_timer_arbiter_if.slave   bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PRESCALE_BITS-1:0] PS_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          grant_q, grant_d;
  logic [NREQ-1:0]          done_q, done_d;
  logic                     busy_q, busy_d;
  logic [BITS-1:0]          count_q, count_d;
  logic [PRESCALE_BITS-1:0] ps_q, ps_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            idx_q, idx_d;

  logic                     found_c;
  logic [IW-1:0]            win_c;
  logic [IW-1:0]            sel_c;
  logic [BITS-1:0]          win_delay_c;

  // Round-robin search: first set req bit starting at ptr+1, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    sel_c   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      sel_c = IW'((32'(ptr_q) + k) % NREQ);
      if (!found_c && bus.req[sel_c]) begin
        found_c = 1'b1;
        win_c   = sel_c;
      end
    end
    win_delay_c = bus.delay[32'(win_c)*BITS +: BITS];
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    ps_d    = ps_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_d = NREQ'(1) << win_c;
          count_d = win_delay_c;
          ps_d    = '0;
          idx_d   = win_c;
          if (win_delay_c == '0) begin
            state_d = DONE;
            done_d  = NREQ'(1) << win_c;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Abort outranks a coincident final tick.
        if (!bus.req[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          ps_d    = '0;
          ptr_d   = idx_q;
        end else begin
          ps_d = ps_q + 1'b1;
          if (ps_q == PS_MAX && count_q != '0) begin
            count_d = count_q - 1'b1;
            if (count_q == BITS'(1)) begin
              state_d = DONE;
              done_d  = NREQ'(1) << idx_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = idx_q;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        ps_d    = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ps_q    <= '0;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Self-checking bench for tick_timer_arbiter (NREQ=4, BITS=8, PRESCALE_BITS=2).
module tb_tick_timer_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned BITS = 8;
  localparam int unsigned PSB  = 2;

  typedef struct {
    logic [3:0] grant;
    int         width;
    logic [7:0] count0;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    int         idx;
    logic [7:0] d;
    logic [3:0] exp_grant;
    int         exp_width;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  exp_t sb[$];
  vec_t vt[5];

  tick_timer_arbiter_if #(.NREQ(NREQ), .BITS(BITS)) bus ();

  tick_timer_arbiter #(.NREQ(NREQ), .BITS(BITS), .PRESCALE_BITS(PSB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int i, input logic [7:0] d);
    bus.delay[i*BITS +: BITS] = d;
  endtask

  // Follows grants, pops the expected record at each grant rise, drops the
  // owner's req when its done is seen, checks width and done placement.
  task automatic watch(input int ngrants);
    exp_t       cur;
    int         got     = 0;
    int         cyc     = 0;
    int         width   = 0;
    int         done_at = 0;
    logic [3:0] prev    = '0;
    logic [3:0] done_v  = '0;
    cur = '{4'b0, 0, 8'b0};
    while (got < ngrants && cyc < 3000) begin
      step();
      cyc++;
      if (bus.grant != '0 && prev == '0) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'(1));
        else cur = sb.pop_front();
        chk("grant", 32'(bus.grant), 32'(cur.grant));
        chk("count_at_grant", 32'(bus.count), 32'(cur.count0));
        chk("busy_at_grant", 32'(bus.busy), 32'(1));
        width   = 0;
        done_at = 0;
        done_v  = '0;
      end
      if (bus.grant != '0) width++;
      if (bus.done != '0) begin
        done_at = width;
        done_v  = bus.done;
        bus.req = bus.req & ~bus.done;
      end
      if (bus.grant == '0 && prev != '0) begin
        chk("grant_width", 32'(width), 32'(cur.width));
        chk("done_cycle", 32'(done_at), 32'(cur.width));
        chk("done_owner", 32'(done_v), 32'(cur.grant));
        got++;
      end
      prev = bus.grant;
    end
    if (got < ngrants) chk("watch_timeout", 32'(got), 32'(ngrants));
  endtask

  initial begin
    logic [3:0] done_seen;
    int         k;

    vt[0] = '{4'b1000, 3, 8'd0,  4'b1000, 1};
    vt[1] = '{4'b0001, 0, 8'd2,  4'b0001, 9};
    vt[2] = '{4'b0100, 2, 8'd1,  4'b0100, 5};
    vt[3] = '{4'b0010, 1, 8'd7,  4'b0010, 29};
    vt[4] = '{4'b1000, 3, 8'd20, 4'b1000, 81};

    rst       = 1'b0;
    bus.req   = '0;
    bus.delay = '0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'(0));
    chk("rst_done",  32'(bus.done),  32'(0));
    chk("rst_busy",  32'(bus.busy),  32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    rst = 1'b1;
    step();

    // Mid-cycle reset with all requests pending, then req0 wins first.
    for (int i = 0; i < 4; i++) set_delay(i, 8'd2);
    bus.req = 4'b1111;
    step();
    step();
    step();
    chk("pre_rst_busy", 32'(bus.busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'(0));
    chk("async_rst_done",  32'(bus.done),  32'(0));
    chk("async_rst_busy",  32'(bus.busy),  32'(0));
    chk("async_rst_count", 32'(bus.count), 32'(0));
    step();
    step();
    rst = 1'b1;
    sb.push_back('{4'b0001, 9, 8'd2});
    watch(1);
    bus.req = '0;
    step();
    step();

    // Single request, delay 3: count steps every 4 cycles, done at 12.
    bus.req = 4'b0010;
    set_delay(1, 8'd3);
    step();
    for (int j = 0; j <= 12; j++) begin
      chk("t2_grant", 32'(bus.grant), 32'(4'b0010));
      chk("t2_count", 32'(bus.count), 32'(3 - j / 4));
      chk("t2_done",  32'(bus.done),  (j == 12) ? 32'(4'b0010) : 32'(0));
      if (j == 12) bus.req = '0;
      step();
    end
    chk("t2_release_grant", 32'(bus.grant), 32'(0));
    chk("t2_release_done",  32'(bus.done),  32'(0));
    step();

    // Table of isolated single requests, including zero delay.
    for (int i = 0; i < 5; i++) begin
      bus.req = vt[i].req;
      set_delay(vt[i].idx, vt[i].d);
      sb.push_back('{vt[i].exp_grant, vt[i].exp_width, vt[i].d});
      watch(1);
      bus.req = '0;
      step();
    end

    // Round-robin order after reset: 0,1,2,3 then 0,2.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) set_delay(i, 8'd1);
    bus.req = 4'b1111;
    sb.push_back('{4'b0001, 5, 8'd1});
    sb.push_back('{4'b0010, 5, 8'd1});
    sb.push_back('{4'b0100, 5, 8'd1});
    sb.push_back('{4'b1000, 5, 8'd1});
    watch(4);
    bus.req = 4'b0101;
    sb.push_back('{4'b0001, 5, 8'd1});
    sb.push_back('{4'b0100, 5, 8'd1});
    watch(2);
    bus.req = '0;
    step();

    // Abort of req2 six cycles into its grant, then 3 served before 0.
    set_delay(2, 8'd5);
    bus.req = 4'b0100;
    step();
    chk("t5_grant", 32'(bus.grant), 32'(4'b0100));
    done_seen = bus.done;
    for (int j = 0; j < 6; j++) begin
      step();
      done_seen = done_seen | bus.done;
    end
    chk("t5_count_before_abort", 32'(bus.count), 32'(4));
    set_delay(0, 8'd1);
    set_delay(3, 8'd1);
    bus.req = 4'b1001;
    step();
    done_seen = done_seen | bus.done;
    chk("t5_abort_grant", 32'(bus.grant), 32'(0));
    chk("t5_abort_count", 32'(bus.count), 32'(0));
    chk("t5_abort_busy",  32'(bus.busy),  32'(0));
    chk("t5_no_done",     32'(done_seen), 32'(0));
    sb.push_back('{4'b1000, 5, 8'd1});
    sb.push_back('{4'b0001, 5, 8'd1});
    watch(2);
    bus.req = '0;
    step();

    // Delay change after grant is ignored.
    set_delay(1, 8'd2);
    bus.req = 4'b0010;
    step();
    chk("t6_grant", 32'(bus.grant), 32'(4'b0010));
    k = 0;
    step();
    k = 1;
    set_delay(1, 8'd9);
    while (bus.done == '0 && k < 60) begin
      step();
      k++;
    end
    chk("t6_done_latency", 32'(k), 32'(8));
    chk("t6_done_owner", 32'(bus.done), 32'(4'b0010));
    bus.req = '0;
    step();
    chk("t6_release", 32'(bus.grant), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tick_timer_arbiter.md
# tick_timer_arbiter

Shares one prescaled down-counter timer among `NREQ` requesters. Each requester asks for a delay, measured in prescaler ticks. A round-robin arbiter grants the timer to one requester at a time. The block counts the delay down and pulses that requester's `done` bit. It sits between lab control FSMs (debounce, display refresh, stopwatch stages) and the shared counter resource, so that each consumer does not need its own counter.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `BITS`, default 8: width of each delay field and of the down-counter.
- `PRESCALE_BITS`, default 4: the prescaler wraps every 2^`PRESCALE_BITS` clk cycles, and each wrap is one tick.

- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (0 = reset).
- `req`, input, `NREQ`: request bits, level-sensitive. Bit i is held high until `done[i]` is seen, or dropped to abort.
- `delay`, input, `NREQ*BITS`: packed delay values; requester i uses `delay[i*BITS +: BITS]`. Sampled only at grant.
- `grant`, output, `NREQ`: one-hot (or zero), registered; the current timer owner.
- `done`, output, `NREQ`: one-hot, one-cycle pulse when the owner's delay expires.
- `busy`, output, 1: high whenever the block is in state RUN or DONE.
- `count`, output, `BITS`: remaining ticks of the current grant; 0 when idle.

## Operation
- Reset values: `grant`=0, `done`=0, `busy`=0, `count`=0, prescaler=0, state=IDLE, rr pointer=`NREQ`-1 (so req0 has first priority).
- State IDLE:
  - If `req`≠0, the winner is the first set bit searching from pointer+1 upward, wrapping modulo `NREQ`.
  - Next edge: `grant[w]`=1, `count`=`delay[w]`, prescaler=0, index latched.
  - Go to RUN if `delay[w]`≠0; go directly to DONE if `delay[w]`=0.
- State RUN:
  - The prescaler increments every cycle, wrapping at 2^`PRESCALE_BITS`-1.
  - On an edge where the prescaler equals 2^`PRESCALE_BITS`-1 (a tick), `count` decrements.
  - If that tick takes `count` from 1 to 0, go to DONE.
  - Abort: if `req[idx]`=0 in any RUN cycle, next edge goes to IDLE with `grant`=0, `count`=0, prescaler=0, and no `done`. The pointer is set to idx.
  - Abort has priority over the final tick when both occur in the same cycle.
- State DONE (exactly one cycle):
  - `done[idx]`=1 and `grant[idx]` is still 1.
  - Next edge: go to IDLE, `grant`=0, `done`=0, pointer=idx.
  - `req` is ignored in DONE, so no abort is possible there.
- Changes to `delay` after grant have no effect. Requests not currently granted are ignored until the next IDLE arbitration.
- If `req[idx]` is still high in the IDLE cycle after DONE, it is re-arbitrated as a fresh request, with lowest priority under round-robin.
- A reset asserted mid-operation immediately forces all outputs to their reset values, independent of the clock.
- `count` never underflows; 0 is terminal.

## Timing
- Grant latency: 1 cycle. A `req` sampled high in IDLE at edge E produces `grant` high after E.
- Done latency: `done` rises D·2^`PRESCALE_BITS` cycles after `grant` rises, where D = latched delay. With D=0, `done` and `grant` rise on the same cycle.
- Grant width: D·2^`PRESCALE_BITS`+1 cycles.
- Back-to-back handover: at least one IDLE cycle between grants, so from the DONE cycle to the next `grant` is 2 edges.
- `count` steps down only on tick edges. It equals D-k after k ticks.
- All outputs are registered; none depend combinationally on `req`.

## Test plan
Parameters for all scenarios: `NREQ`=4, `BITS`=8, `PRESCALE_BITS`=2 (1 tick = 4 cycles).
1. Reset: drive `rst`=0 mid-cycle with `req`=4'b1111 -> all outputs 0 immediately. After release, the first grant goes to `req[0]`.
2. Single request: `req[1]`=1 with delay 3 -> `grant`=4'b0010 one cycle later. `count` goes 3, 2, 1, 0 at 4-cycle steps. `done`=4'b0010 for one cycle, 12 cycles after grant rose. `grant` returns to 0 on the following edge.
3. Round-robin: all `req` high, every delay=1, each requester drops `req` after its done -> grant order 0, 1, 2, 3. Re-raising `req[0]` and `req[2]` then yields 0, then 2. Each grant lasts 5 cycles.
4. Zero delay: `req[3]` with delay 0 -> `grant`=4'b1000 and `done`=4'b1000 on the same cycle for one cycle. `count` stays 0.
5. Abort: `req[2]` with delay 5, `req[2]` dropped 6 cycles after grant -> `grant`=0 on the next edge and no `done`. A pending `req[0]`/`req[3]` pair is then served as `req[3]` first, because the pointer is 2.
6. Stale delay: change `delay[1]` from 2 to 9 one cycle after grant -> `done[1]` still arrives 8 cycles after grant.
